// File: rtl/irq_pend_pkg.sv
// Shared constants and types for the 4-line interrupt pending block.
//   N_REQ     : number of request lines
//   ID_W      : width of an acknowledge index
//   req_vec_t : one bit per request line
package irq_pend_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    typedef logic [N_REQ-1:0] req_vec_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronised output (two cycles of latency)
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/irq_pend_4.sv
// Four-line interrupt pending register with edge/level capture, per-bit
// acknowledge, masking and sticky overrun flags.
// Optional macro IRQ_PEND_SYNC_EN: when defined each req_in bit passes
// through a 2-flop synchroniser before capture (two extra cycles latency);
// otherwise req_in must already be synchronous to clk.
// Ports:
//   clk     : clock, all state on rising edge
//   rst_n   : asynchronous active-low reset
//   req_in  : raw request lines (bit 3 highest priority downstream)
//   mask    : 1 = bit hidden from pend/irq but still captured
//   ack     : one-cycle acknowledge strobe
//   ack_id  : index of the acknowledged request
//   clr_ovr : clears all overrun flags
//   pend    : registered pending vector, raw pending masked by ~mask
//   irq     : registered, any bit of pend set
//   overrun : sticky per-bit lost-event flags
module irq_pend_4
    import irq_pend_pkg::*;
#(
    parameter int unsigned EDGE_MODE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  req_vec_t        req_in,
    input  req_vec_t        mask,
    input  logic            ack,
    input  logic [ID_W-1:0] ack_id,
    input  logic            clr_ovr,
    output req_vec_t        pend,
    output logic            irq,
    output req_vec_t        overrun
);

    req_vec_t s;
    req_vec_t s_q;
    req_vec_t evt;
    req_vec_t ack_hit;
    req_vec_t ovr_set;
    req_vec_t praw_q, praw_d;
    req_vec_t pend_q, pend_d;
    req_vec_t ovr_q, ovr_d;
    logic     irq_q;

`ifdef IRQ_PEND_SYNC_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_sync
        sync_2ff u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (req_in[i]),
            .q     (s[i])
        );
    end
`else
    assign s = req_in;
`endif

    always_comb begin
        evt     = (EDGE_MODE != 0) ? (s & ~s_q) : s;
        ack_hit = '0;
        if (ack) begin
            ack_hit[ack_id] = 1'b1;
        end
        // A new event always wins over an ack on the same bit.
        praw_d  = evt | (praw_q & ~ack_hit);
        // Level capture re-asserts every cycle by design, so it never overruns.
        ovr_set = (EDGE_MODE != 0) ? (evt & praw_q & ~ack_hit) : '0;
        ovr_d   = clr_ovr ? ovr_set : (ovr_q | ovr_set);
        // Mask from the next-state so pend shows up on the capturing edge.
        pend_d  = praw_d & ~mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            praw_q <= '0;
            pend_q <= '0;
            irq_q  <= 1'b0;
            ovr_q  <= '0;
        end else begin
            s_q    <= s;
            praw_q <= praw_d;
            pend_q <= pend_d;
            irq_q  <= |pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign pend    = pend_q;
    assign irq     = irq_q;
    assign overrun = ovr_q;

endmodule
